// File: rtl/mii_pkg.sv
// XGMII control characters, encoder FSM states and the word-level helpers
// shared by the transmit encoder.
package mii_pkg;

    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_ERROR = 8'hFE;

    localparam logic [63:0] IDLE_WORD  = {8{CH_IDLE}};
    localparam logic [63:0] ERROR_WORD = {8{CH_ERROR}};
    localparam logic [7:0]  CTRL_ALL   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TERM,
        ST_IPG
    } state_t;

    // Lanes below nbytes keep data, lane nbytes gets Terminate, the rest Idle.
    // nbytes=0 yields the stand-alone terminate word (lane 0 = 0xFD).
    function automatic logic [71:0] term_merge(input logic [63:0] data,
                                               input logic [3:0]  nbytes);
        logic [63:0] txd;
        logic [7:0]  txc;
        int          n;
        n   = int'(nbytes);
        txd = IDLE_WORD;
        txc = CTRL_ALL;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                txd[8*i +: 8] = data[8*i +: 8];
                txc[i]        = 1'b0;
            end else if (i == n) begin
                txd[8*i +: 8] = CH_TERM;
            end
        end
        return {txd, txc};
    endfunction

endpackage

// File: rtl/xgmii_tx_encoder.sv
// XGMII transmit encoder: wraps 64-bit MAC frame beats with Start/Terminate
// control characters, aborts with an error word, and enforces inter-packet gap.
module xgmii_tx_encoder
    import mii_pkg::*;
#(
    parameter int IPG_WORDS = 2
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [63:0] i_data,
    input  logic        i_last,
    input  logic [3:0]  i_last_nbytes,
    output logic        o_ready,
    output logic [63:0] o_txd,
    output logic [7:0]  o_txc,
    output logic        o_err,
    output logic [15:0] o_frame_cnt
);

    localparam logic [15:0] IPG_LOAD = 16'(IPG_WORDS);
    // With no gap requested the frame end drops straight back to IDLE.
    localparam state_t POST_FRAME = (IPG_WORDS == 0) ? ST_IDLE : ST_IPG;

    state_t      state;
    logic [15:0] ipg_cnt;
    logic        accept;
    logic        nbytes_ok;
    logic [71:0] merged;

    assign o_ready   = (state == ST_IDLE) || (state == ST_DATA);
    assign accept    = i_valid && o_ready;
    assign nbytes_ok = (i_last_nbytes != 4'd0) && (i_last_nbytes <= 4'd8);
    assign merged    = term_merge(i_data, i_last_nbytes);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IPG;
            ipg_cnt     <= IPG_LOAD;
            o_txd       <= IDLE_WORD;
            o_txc       <= CTRL_ALL;
            o_err       <= 1'b0;
            o_frame_cnt <= 16'd0;
        end else begin
            o_txd <= IDLE_WORD;
            o_txc <= CTRL_ALL;
            o_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (i_last) begin
                            // A one-beat frame is a runt: abort it.
                            o_txd   <= ERROR_WORD;
                            o_err   <= 1'b1;
                            state   <= POST_FRAME;
                            ipg_cnt <= IPG_LOAD;
                        end else begin
                            o_txd <= {i_data[63:8], CH_START};
                            o_txc <= 8'h01;
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (!accept || (i_last && !nbytes_ok)) begin
                        o_txd   <= ERROR_WORD;
                        o_err   <= 1'b1;
                        state   <= POST_FRAME;
                        ipg_cnt <= IPG_LOAD;
                    end else if (!i_last) begin
                        o_txd <= i_data;
                        o_txc <= 8'h00;
                    end else if (i_last_nbytes == 4'd8) begin
                        o_txd <= i_data;
                        o_txc <= 8'h00;
                        state <= ST_TERM;
                    end else begin
                        {o_txd, o_txc} <= merged;
                        o_frame_cnt    <= o_frame_cnt + 16'd1;
                        state          <= POST_FRAME;
                        ipg_cnt        <= IPG_LOAD;
                    end
                end
                ST_TERM: begin
                    {o_txd, o_txc} <= term_merge(64'd0, 4'd0);
                    o_frame_cnt    <= o_frame_cnt + 16'd1;
                    state          <= POST_FRAME;
                    ipg_cnt        <= IPG_LOAD;
                end
                ST_IPG: begin
                    if (ipg_cnt <= 16'd1) begin
                        state <= ST_IDLE;
                    end else begin
                        ipg_cnt <= ipg_cnt - 16'd1;
                    end
                end
                default: begin
                    state   <= ST_IPG;
                    ipg_cnt <= IPG_LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/xgmii_tx_encoder.md
XGMII_TX_ENCODER -- requirements
Module: xgmii_tx_encoder

Interface
REQ-001 The block SHALL have parameter IPG_WORDS, default 2, giving the number of full idle words inserted after each frame's terminate or error word.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock for all state.
REQ-003 i_rst_n  in  1  asynchronous active-low reset.
REQ-004 i_valid  in  1  input beat valid.
REQ-005 i_data  in  64  MAC frame beat; byte n = bits [8n+7:8n]; byte 0 is first on the wire; the first beat carries preamble+SFD.
REQ-006 i_last  in  1  marks the final beat of a frame.
REQ-007 i_last_nbytes  in  4  valid bytes in the last beat, 1..8, low lanes first; ignored when i_last=0.
REQ-008 o_ready  out  1  beat accepted on a cycle where i_valid & o_ready.
REQ-009 o_txd  out  64  XGMII data; lane n = bits [8n+7:8n].
REQ-010 o_txc  out  8  XGMII control; bit n=1 means lane n carries a control character.
REQ-011 o_err  out  1  one-cycle pulse on a frame abort.
REQ-012 o_frame_cnt  out  16  count of frames terminated cleanly; wraps from 0xFFFF to 0.

Function
REQ-013 Control characters SHALL be: Idle 0x07, Start 0xFB, Terminate 0xFD, Error 0xFE.
REQ-014 The FSM SHALL have states IDLE, DATA, TERM and IPG.
REQ-015 o_ready SHALL equal 1 in IDLE and DATA, and 0 in TERM and IPG.
REQ-016 o_txd and o_txc SHALL be registered: each accepted beat appears exactly 1 cycle after acceptance.
REQ-017 IDLE, no accept: the block SHALL output the idle word (all lanes 0x07, o_txc=0xFF).
REQ-018 IDLE, accept with i_last=0: the block SHALL output the beat with lane 0 replaced by 0xFB, o_txc=0x01, and go to DATA.
REQ-019 IDLE, accept with i_last=1 (runt): the block SHALL output the error word (all lanes 0xFE, o_txc=0xFF), pulse o_err, and go to IPG.
REQ-020 DATA, accept with i_last=0: the block SHALL output the beat unchanged with o_txc=0x00.
REQ-021 DATA, accept with i_last=1 and N=i_last_nbytes<8: lanes 0..N-1 SHALL carry data, lane N 0xFD, lanes N+1..7 0x07; o_txc bits N..7 SHALL be 1; o_frame_cnt SHALL increment; next state IPG.
REQ-022 DATA, accept with i_last=1 and N=8: the block SHALL output the full data word with o_txc=0x00 and go to TERM.
REQ-023 TERM SHALL output lane 0 = 0xFD and lanes 1..7 = 0x07 with o_txc=0xFF, increment o_frame_cnt, and go to IPG.
REQ-024 DATA with i_valid=0 (underrun) SHALL output the error word, pulse o_err, and go to IPG; the frame is not counted.
REQ-025 i_last_nbytes of 0 or greater than 8 on a last beat SHALL be treated as an underrun abort (REQ-024).
REQ-026 On entry to IPG, a down-counter SHALL load IPG_WORDS; IPG SHALL output idle words, decrement each cycle, and go to IDLE after IPG_WORDS cycles.
REQ-027 A Start SHALL only ever appear in lane 0; a frame therefore starts no earlier than the first cycle in IDLE.
REQ-028 An o_frame_cnt increment and an o_err pulse SHALL never occur in the same cycle.

Reset
REQ-029 While i_rst_n=0, the outputs SHALL be: o_txd=0x0707070707070707, o_txc=0xFF, o_err=0, o_frame_cnt=0.
REQ-030 Reset SHALL place the FSM in IPG with the counter at IPG_WORDS, so o_ready=0 for IPG_WORDS cycles after release.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no terminate and no error word emitted; the output is idle immediately.

Structure
REQ-032 Shared package mii_pkg SHALL hold the four control-character constants, the FSM state enum, and the idle and error word constants.
REQ-033 A combinational function term_merge(data, nbytes) returning {txd, txc} SHALL live in mii_pkg; no sub-module is required.

Verification
REQ-034 3-beat frame: beats 0xD555555555555555, A, B with last nbytes=4 -> lane0 0xFB ctrl 0x01; A ctrl 0x00; B lanes0-3, lane4 0xFD, lanes5-7 0x07, ctrl 0xF0; o_frame_cnt=1; then 2 idle words.
REQ-035 Last beat with nbytes=8 -> data word ctrl 0x00, then 0x07070707070707FD ctrl 0xFF, then o_ready=0 for 2 more cycles.
REQ-036 i_valid dropped after beat 1 of 4 -> error word 0xFEFEFEFEFEFEFEFE ctrl 0xFF, o_err pulse, o_frame_cnt unchanged.
REQ-037 i_valid held with back-to-back frames -> exactly IPG_WORDS idle words between each terminate word and the next 0xFB.
REQ-038 Reset pulsed mid-frame -> idle outputs during reset; o_ready=0 for 2 cycles after release; the next frame encodes normally.
REQ-039 Force o_frame_cnt to 0xFFFF, send one frame -> o_frame_cnt=0x0000.
